// File: rtl/sm3_pkg.sv
// Shared constants for the SM3 message padder: block geometry, pad word, FSM encodings.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sm3_pkg;

    localparam int          SM3_BLOCK_WORDS = 16;
    localparam logic [3:0]  SM3_LEN_WORD_HI = 4'd14;
    localparam logic [31:0] SM3_PAD_WORD    = 32'h8000_0000;
    localparam int          SM3_GAP_CYCLES  = 68;

    // Padder FSM encodings; kept as plain constants for legacy tools.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DATA   = 3'd1;
    localparam logic [2:0] ST_PAD80  = 3'd2;
    localparam logic [2:0] ST_ZERO   = 3'd3;
    localparam logic [2:0] ST_LEN_HI = 3'd4;
    localparam logic [2:0] ST_LEN_LO = 3'd5;
    localparam logic [2:0] ST_GAP    = 3'd6;

endpackage

// File: rtl/sm3_last_word_mask.sv
// Keeps the valid leading bytes of the final message word and inserts the 0x80 pad byte after them.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module sm3_last_word_mask (
    input  logic [31:0] i_data,
    input  logic [1:0]  i_bytes,
    output logic [31:0] o_word
);

    // A count of 0 means all four bytes are message, so the 0x80 goes in a separate word.
    always_comb begin
        case (i_bytes)
            2'd1:    o_word = {i_data[31:24], 8'h80, 16'h0000};
            2'd2:    o_word = {i_data[31:16], 8'h80, 8'h00};
            2'd3:    o_word = {i_data[31:8],  8'h80};
            default: o_word = i_data;
        endcase
    end

endmodule

// File: rtl/sm3_msg_padder.sv
// Pads a big-endian word stream per SM3 and feeds 16-word blocks to the compression core.
// Latency: one cycle from accepted input word (or generated pad word) to the message register.
// Backpressure: core_busy freezes the outputs and drops in_ready; a fixed gap separates blocks.
module sm3_msg_padder
    import sm3_pkg::*;
#(
    parameter int GAP_CYCLES = SM3_GAP_CYCLES,
    parameter int LEN_W      = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_last,
    input  logic [1:0]  in_bytes,
    input  logic        core_busy,
    output logic [31:0] message,
    output logic        valid_out,
    output logic        m_sm3,
    output logic        pad_done
);

    localparam int WIDX_W = $clog2(SM3_BLOCK_WORDS);
    localparam int GAP_W  = $clog2(GAP_CYCLES + 1) + 1;

    logic [2:0]        r_state;
    logic [2:0]        r_ret;
    logic [WIDX_W-1:0] r_widx;
    logic [LEN_W-1:0]  r_bitlen;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic [31:0]       r_message;
    logic              r_valid_out;
    logic              r_m_sm3;
    logic              r_pad_done;

    logic [31:0]       w_masked;
    logic              w_beat;
    logic [31:0]       w_word;
    logic [2:0]        w_tgt;
    logic [2:0]        w_next;
    logic [LEN_W-1:0]  w_bitlen_nxt;
    logic [WIDX_W-1:0] w_widx_nxt;
    logic              w_in_ready;
    logic              w_gap_done;

    sm3_last_word_mask u_mask (
        .i_data  (in_data),
        .i_bytes (in_bytes),
        .o_word  (w_masked)
    );

    assign w_widx_nxt = r_widx + WIDX_W'(1);
    assign w_gap_done = (r_gap_cnt == GAP_W'(GAP_CYCLES));

    // Decide whether this cycle produces a word, which word, and the state it leads to.
    always_comb begin
        w_beat       = 1'b0;
        w_word       = '0;
        w_tgt        = r_state;
        w_bitlen_nxt = r_bitlen;
        w_in_ready   = 1'b0;
        case (r_state)
            ST_IDLE, ST_DATA: begin
                w_in_ready = !core_busy;
                if (in_valid && !core_busy) begin
                    w_beat = 1'b1;
                    if (in_last) begin
                        w_word       = w_masked;
                        w_bitlen_nxt = r_bitlen + ((in_bytes == 2'd0) ? LEN_W'(32)
                                                                      : LEN_W'({in_bytes, 3'b000}));
                        w_tgt        = (in_bytes == 2'd0) ? ST_PAD80 : ST_ZERO;
                    end else begin
                        w_word       = in_data;
                        w_bitlen_nxt = r_bitlen + LEN_W'(32);
                        w_tgt        = ST_DATA;
                    end
                end
            end
            ST_PAD80: begin
                w_beat = !core_busy;
                w_word = SM3_PAD_WORD;
                w_tgt  = ST_ZERO;
            end
            ST_ZERO: begin
                w_beat = !core_busy;
                w_tgt  = ST_ZERO;
            end
            ST_LEN_HI: begin
                w_beat = !core_busy;
                w_word = r_bitlen[LEN_W-1:32];
                w_tgt  = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                w_beat       = !core_busy;
                w_word       = r_bitlen[31:0];
                w_tgt        = ST_IDLE;
                w_bitlen_nxt = '0;
            end
            default: ;
        endcase
    end

    // A block wrap always detours through GAP; zero fill stops when the length words are due.
    always_comb begin
        w_next = w_tgt;
        if (w_widx_nxt == '0) begin
            w_next = ST_GAP;
        end else if (w_tgt == ST_ZERO && w_widx_nxt == SM3_LEN_WORD_HI) begin
            w_next = ST_LEN_HI;
        end
    end

    // FSM, word index, bit length and inter-block gap counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_ret     <= ST_IDLE;
            r_widx    <= '0;
            r_bitlen  <= '0;
            r_gap_cnt <= '0;
        end else if (w_beat) begin
            r_state   <= w_next;
            r_ret     <= w_tgt;
            r_widx    <= w_widx_nxt;
            r_bitlen  <= w_bitlen_nxt;
            r_gap_cnt <= '0;
        end else if (r_state == ST_GAP) begin
            if (!w_gap_done) begin
                r_gap_cnt <= r_gap_cnt + GAP_W'(1);
            end else if (!core_busy) begin
                r_state <= r_ret;
            end
        end
    end

    // Output registers hold while the core is busy; idle non-busy cycles become bubbles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_message   <= '0;
            r_valid_out <= 1'b0;
            r_m_sm3     <= 1'b0;
            r_pad_done  <= 1'b0;
        end else if (!core_busy) begin
            r_valid_out <= w_beat;
            r_m_sm3     <= w_beat && (r_widx == '0);
            r_pad_done  <= w_beat && (r_state == ST_LEN_LO);
            if (w_beat) begin
                r_message <= w_word;
            end
        end else begin
            r_pad_done <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign message   = r_message;
    assign valid_out = r_valid_out;
    assign m_sm3     = r_m_sm3;
    assign pad_done  = r_pad_done;

endmodule

// File: tb/tb_sm3_msg_padder.sv
// Drives byte messages into the padder and compares every emitted word against a padded-byte model.
// Latency: n/a (bench).
// Backpressure: exercises core_busy stalls, input bubbles and an asynchronous reset mid-block.
module tb_sm3_msg_padder;

    localparam int GAP = 68;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic [1:0]  in_bytes;
    logic        core_busy;
    logic [31:0] message;
    logic        valid_out;
    logic        m_sm3;
    logic        pad_done;

    int total  = 0;
    int passes = 0;

    byte unsigned msg[$];
    logic [31:0]  exp_q[$];

    sm3_msg_padder #(.GAP_CYCLES(GAP), .LEN_W(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_bytes  (in_bytes),
        .core_busy (core_busy),
        .message   (message),
        .valid_out (valid_out),
        .m_sm3     (m_sm3),
        .pad_done  (pad_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    // Reference: pad the byte string the textbook way, then cut it into big-endian words.
    task automatic build_expected();
        byte unsigned p[$];
        logic [63:0]  bl;
        p = msg;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        bl = 64'(msg.size()) * 64'd8;
        for (int k = 7; k >= 0; k--) p.push_back(8'(bl >> (8 * k)));
        exp_q.delete();
        for (int i = 0; i < p.size(); i += 4) exp_q.push_back({p[i], p[i+1], p[i+2], p[i+3]});
    endtask

    // Input word s of the message; bytes past the end are random junk the padder must mask.
    function automatic logic [31:0] src_word(input int s);
        logic [31:0] w;
        w = '0;
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx = 4 * s + k;
            w[31 - 8*k -: 8] = (idx < msg.size()) ? msg[idx] : 8'($urandom);
        end
        return w;
    endfunction

    task automatic fill_rand(input int n);
        msg.delete();
        for (int i = 0; i < n; i++) msg.push_back(8'($urandom));
    endtask

    task automatic run_msg(input int stall_at, input int abort_at, input bit rnd);
        int n, nw, src, got, last_cyc, stall_left, bub_left;
        bit acc, upd, aborted, exp_pd;
        logic [31:0] p_msg;
        logic p_vld, p_m;
        n  = msg.size();
        nw = (n + 3) / 4;
        build_expected();
        src = 0; got = 0; last_cyc = 0; stall_left = 0; bub_left = 0;
        acc = 1'b0; upd = 1'b1; aborted = 1'b0;
        core_busy = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        p_msg = message; p_vld = valid_out; p_m = m_sm3;
        for (int cyc = 0; cyc < 6000 && got < exp_q.size(); cyc++) begin
            @(negedge clk);
            if (acc) src++;
            if (!upd) begin
                chk("hold_message", message, p_msg);
                chk("hold_valid", valid_out, p_vld);
                chk("hold_m_sm3", m_sm3, p_m);
            end
            exp_pd = upd && valid_out && (got == exp_q.size() - 1);
            chk("pad_done", pad_done, exp_pd);
            if (upd && valid_out) begin
                chk("word", message, exp_q[got]);
                chk("m_sm3", m_sm3, (got % 16) == 0);
                if ((got % 16) == 0 && got > 0) chk("gap", (cyc - last_cyc - 1) >= GAP, 1);
                last_cyc = cyc;
                got++;
                if (got == stall_at) begin stall_left = 5; bub_left = 8; end
                if (got == abort_at) begin aborted = 1'b1; break; end
            end
            p_msg = message; p_vld = valid_out; p_m = m_sm3;
            if (stall_left > 0) begin
                core_busy = 1'b1;
                stall_left--;
            end else begin
                core_busy = rnd && ($urandom_range(0, 4) == 0);
            end
            if (in_valid && !acc) begin
                // word offered but not yet taken stays on the bus
            end else if (bub_left > 0 || src >= nw || (rnd && $urandom_range(0, 3) == 0)) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = src_word(src);
                in_last  = (src == nw - 1);
                in_bytes = (src == nw - 1) ? 2'(n % 4) : 2'($urandom);
            end
            if (bub_left > 0) bub_left--;
            #1;
            acc = in_valid && in_ready;
            upd = !core_busy;
            if (core_busy) chk("in_ready_busy", in_ready, 0);
        end
        if (aborted) begin
            #2 rst = 1'b0;
            #1;
            chk("arst_message", message, 0);
            chk("arst_valid", valid_out, 0);
            chk("arst_m_sm3", m_sm3, 0);
            chk("arst_pad_done", pad_done, 0);
            in_valid = 1'b0; core_busy = 1'b0; in_last = 1'b0;
            @(negedge clk);
            #2 rst = 1'b1;
        end else begin
            chk("complete", got, exp_q.size());
        end
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_bytes = '0; core_busy = 1'b0;
        #23;
        chk("reset_message", message, 0);
        chk("reset_valid", valid_out, 0);
        chk("reset_m_sm3", m_sm3, 0);
        chk("reset_pad_done", pad_done, 0);
        @(negedge clk);
        #2 rst = 1'b1;

        msg = '{8'h61, 8'h62, 8'h63};
        run_msg(-1, -1, 1'b0);

        msg.delete();
        for (int i = 0; i < 64; i++) msg.push_back(8'h61 + 8'(i % 4));
        run_msg(-1, -1, 1'b0);

        fill_rand(56);
        run_msg(-1, -1, 1'b0);

        fill_rand(40);
        run_msg(7, -1, 1'b0);

        fill_rand(48);
        run_msg(-1, 9, 1'b0);

        msg = '{8'h61, 8'h62, 8'h63};
        run_msg(-1, -1, 1'b0);

        for (int t = 0; t < 5; t++) begin
            fill_rand($urandom_range(1, 130));
            run_msg(-1, -1, 1'b1);
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
